// File: rtl/vlog_fsm_arb_n.sv
// Round-robin arbiter with a one-hot IDLE/GRANT FSM and one idle cycle between grants.
// Define ARB_TIMEOUT_EN to compile in forced release after HOLD_MAX grant cycles.
module vlog_fsm_arb_n #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       timeout
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("vlog_fsm_arb_n: NUM_REQ must be in 2..16");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("vlog_fsm_arb_n: HOLD_MAX must be in 2..255");
    end

    typedef enum logic [1:0] {
        StIdle  = 2'b01,
        StGrant = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IdW-1:0]     gnt_id_q, gnt_id_d;
    logic               busy_q, busy_d;
    logic [IdW-1:0]     ptr_q, ptr_d;

    logic               win_valid;
    logic [IdW-1:0]     win_id;
    logic               owner_req;
    logic [IdW-1:0]     ptr_after_owner;
    logic               force_rel;

    assign owner_req       = req[gnt_id_q];
    assign ptr_after_owner = (gnt_id_q == IdW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IdW'(1);

    // First requester found scanning upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned    idx_int;
        logic [IdW-1:0] idx;
        win_valid = 1'b0;
        win_id    = '0;
        idx_int   = 0;
        idx       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx_int = 32'(ptr_q) + off;
            if (idx_int >= NUM_REQ) begin
                idx_int = idx_int - NUM_REQ;
            end
            idx = IdW'(idx_int);
            if (!win_valid && req[idx]) begin
                win_valid = 1'b1;
                win_id    = idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HoldTop = 8'(HOLD_MAX - 1);

    logic [7:0] hold_q, hold_d;
    logic       timeout_q;
    logic       others_req;

    assign others_req = |(req & ~gnt_q);
    assign force_rel  = (state_q == StGrant) && (hold_q == HoldTop) && owner_req && others_req;

    // Cleared whenever GRANT is entered or left; saturates while the grant persists.
    always_comb begin
        hold_d = hold_q;
        if (state_q != StGrant || state_d != StGrant) begin
            hold_d = '0;
        end else if (hold_q != HoldTop) begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= force_rel;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            StIdle: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                if (win_valid) begin
                    gnt_d    = NUM_REQ'(1) << win_id;
                    gnt_id_d = win_id;
                    busy_d   = 1'b1;
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                if (!owner_req || force_rel) begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
                    ptr_d    = ptr_after_owner;
                    state_d  = StIdle;
                end
            end
            default: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_vlog_fsm_arb_n.sv
// Directed self-checking bench for vlog_fsm_arb_n (NUM_REQ=4, HOLD_MAX=4).
module tb_vlog_fsm_arb_n;
    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_assert = 0;
    int n_fail   = 0;

    vlog_fsm_arb_n #(
        .NUM_REQ  (4),
        .HOLD_MAX (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                         input logic eb, input logic et);
        n_assert++;
        assert ({gnt, gnt_id, busy, timeout} === {eg, eid, eb, et})
        else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%b id=%0d busy=%b timeout=%b, expected gnt=%b id=%0d busy=%b timeout=%b",
                   tag, gnt, gnt_id, busy, timeout, eg, eid, eb, et);
        end
    endtask

    // Pulses reset between edges; call just after an edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        #2;
        check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // ptr=0, requesters 1 and 3
        req = 4'b1010;
        tick();
        check("grant_1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000;
        tick();
        check("release_1", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check("grant_3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check("release_3", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        check("idle_after_3", 4'b0000, 2'd0, 1'b0, 1'b0);

        // ptr wrapped to 0: all request, each owner holds two cycles
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] own;
            logic [3:0] onehot;
            own    = 2'(k % 4);
            onehot = 4'b0001 << own;
            tick();
            check("rr_grant_c1", onehot, own, 1'b1, 1'b0);
            tick();
            check("rr_grant_c2", onehot, own, 1'b1, 1'b0);
            req = (k == 4) ? 4'b0000 : (4'b1111 & ~onehot);
            tick();
            check("rr_idle_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
            req = (k == 4) ? 4'b0000 : 4'b1111;
        end

        // ptr=1; requester 0 wins after scanning 1,2,3,0
        req = 4'b0001;
        tick();
        check("pre_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
        tick();
        check("pre_reset_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        req   = 4'b0100;
        tick();
        check("post_reset_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        check("post_reset_release", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        pulse_reset();
        req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_hold_0", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        tick();
        check("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        check("to_next_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0001;
        tick();
        check("to_release_1", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("to_sole_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        req = 4'b0000;
        tick();
        check("to_sole_release", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
        pulse_reset();
        req = 4'b0011;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("no_to_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
        req = 4'b0000;
        tick();
        check("no_to_release", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
